instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/rv32_isa_pkg.sv | 50 +++++
 rtl/imm_pack.sv | 65 ++++++
 rtl/instr_encoder.sv | 94 +++++++++
 3 files changed

// File: rtl/rv32_isa_pkg.sv
// Shared RV32I constants: instruction classes, opcodes, the canonical NOP and
// encoder error codes. Decode imports the same package so both sides agree.
package rv32_isa_pkg;

  typedef enum logic [3:0] {
    CLS_LUI    = 4'd0,
    CLS_AUIPC  = 4'd1,
    CLS_BRANCH = 4'd2,
    CLS_JALR   = 4'd3,
    CLS_JAL    = 4'd4,
    CLS_LOAD   = 4'd5,
    CLS_STORE  = 4'd6,
    CLS_OPIMM  = 4'd7,
    CLS_OP     = 4'd8
  } op_class_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ADDI x0,x0,0; substituted for any word that cannot be encoded.
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_CLASS = 2'd3;

  function automatic logic [6:0] opcode_of(input logic [3:0] cls);
    case (op_class_e'(cls))
      CLS_LUI:    opcode_of = OPC_LUI;
      CLS_AUIPC:  opcode_of = OPC_AUIPC;
      CLS_BRANCH: opcode_of = OPC_BRANCH;
      CLS_JALR:   opcode_of = OPC_JALR;
      CLS_JAL:    opcode_of = OPC_JAL;
      CLS_LOAD:   opcode_of = OPC_LOAD;
      CLS_STORE:  opcode_of = OPC_STORE;
      CLS_OPIMM:  opcode_of = OPC_OPIMM;
      CLS_OP:     opcode_of = OPC_OP;
      default:    opcode_of = OPC_OPIMM;
    endcase
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Places the immediate into its instruction-word bit positions for each class
// and flags range, alignment and illegal-class errors. Purely combinational.
module imm_pack
  import rv32_isa_pkg::*;
(
  input  logic [3:0]  op_class,
  input  logic [2:0]  func3,
  input  logic        alt,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic [1:0]  err_code
);

  logic fits12;
  logic fits13;
  logic fits21;
  logic is_shift;

  assign fits12   = (imm[31:11] == {21{imm[11]}});
  assign fits13   = (imm[31:12] == {20{imm[12]}});
  assign fits21   = (imm[31:20] == {12{imm[20]}});
  assign is_shift = (func3 == 3'b001) || (func3 == 3'b101);

  // Alignment is tested before range so a misaligned branch/jump reports code 2.
  always_comb begin
    imm_bits = '0;
    err_code = ERR_NONE;
    case (op_class_e'(op_class))
      CLS_LUI, CLS_AUIPC: begin
        imm_bits = {imm[31:12], 12'b0};
        if (imm[11:0] != 12'd0) err_code = ERR_RANGE;
      end
      CLS_JAL: begin
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        if (imm[0])       err_code = ERR_ALIGN;
        else if (!fits21) err_code = ERR_RANGE;
      end
      CLS_BRANCH: begin
        imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        if (imm[0])       err_code = ERR_ALIGN;
        else if (!fits13) err_code = ERR_RANGE;
      end
      CLS_STORE: begin
        imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        if (!fits12) err_code = ERR_RANGE;
      end
      CLS_JALR, CLS_LOAD: begin
        imm_bits = {imm[11:0], 20'b0};
        if (!fits12) err_code = ERR_RANGE;
      end
      CLS_OPIMM: begin
        if (is_shift) begin
          imm_bits = {1'b0, alt, 5'b0, imm[4:0], 20'b0};
          if (imm[31:5] != 27'd0) err_code = ERR_RANGE;
        end else begin
          imm_bits = {imm[11:0], 20'b0};
          if (!fits12) err_code = ERR_RANGE;
        end
      end
      CLS_OP: imm_bits = '0;
      default: err_code = ERR_CLASS;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with one output register stage, valid/ready
// handshake on both sides, a byte-address counter and a sticky error flag.
module instr_encoder
  import rv32_isa_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_class,
  input  logic [2:0]        func3,
  input  logic              alt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code
);

  logic [31:0]       imm_bits;
  logic [1:0]        imm_err;
  logic [31:0]       enc_word;
  logic [6:0]        opc;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_base;
  logic              accept;

  imm_pack u_imm_pack (
    .op_class (op_class),
    .func3    (func3),
    .alt      (alt),
    .imm      (imm),
    .imm_bits (imm_bits),
    .err_code (imm_err)
  );

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign addr_base = addr_load ? addr_in : addr_cnt;
  assign opc       = opcode_of(op_class);

  always_comb begin
    enc_word = NOP_WORD;
    case (op_class_e'(op_class))
      CLS_LUI, CLS_AUIPC, CLS_JAL:
        enc_word = {imm_bits[31:12], rd, opc};
      CLS_JALR, CLS_LOAD, CLS_OPIMM:
        enc_word = {imm_bits[31:20], rs1, func3, rd, opc};
      CLS_BRANCH, CLS_STORE:
        enc_word = imm_bits | {7'b0, rs2, rs1, func3, 5'b0, opc};
      CLS_OP:
        enc_word = {1'b0, alt, 5'b0, rs2, rs1, func3, rd, opc};
      default:
        enc_word = NOP_WORD;
    endcase
    if (imm_err != ERR_NONE) enc_word = NOP_WORD;
  end

  // A held word blocks acceptance, so out_* only change on accept or drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_addr  <= '0;
      addr_cnt  <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_word  <= enc_word;
        out_addr  <= addr_base;
        addr_cnt  <= addr_base + ADDR_W'(4);
        if (imm_err != ERR_NONE) begin
          err <= 1'b1;
          if (!err) err_code <= imm_err;
        end
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (addr_load) addr_cnt <= addr_in;
      end
    end
  end

endmodule
